// File: rtl/bram_sync_be.sv
// bram_sync_be: byte-enabled synchronous BRAM with a clear sweep and 1/2-cycle read latency.
// Revision 1.0
`default_nettype none

module bram_sync_be #(
  parameter int BRAM_ADDR_WIDTH = 6,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int READ_LATENCY    = 1,
  parameter int RDW_MODE        = 0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         clear_req,
  output logic                         busy,
  input  logic                         rd_en,
  input  logic [BRAM_ADDR_WIDTH-1:0]   rd_addr,
  input  logic                         wr_en,
  input  logic [BRAM_ADDR_WIDTH-1:0]   wr_addr,
  input  logic [BRAM_DATA_WIDTH/8-1:0] wr_be,
  input  logic [BRAM_DATA_WIDTH-1:0]   din,
  output logic [BRAM_DATA_WIDTH-1:0]   dout,
  output logic                         rd_valid
);

  localparam int C_DEPTH  = 2 ** BRAM_ADDR_WIDTH;
  localparam int C_NBYTES = BRAM_DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                       state_q;
  logic [BRAM_ADDR_WIDTH-1:0]   sweep_q;
  logic [BRAM_DATA_WIDTH-1:0]   mem_q [C_DEPTH];
  logic [BRAM_DATA_WIDTH-1:0]   dout_q;
  logic                         rd_valid_q;

  logic                         w_rd_fire;
  logic                         w_wr_fire;
  logic [BRAM_DATA_WIDTH-1:0]   w_merged;
  logic [BRAM_DATA_WIDTH-1:0]   w_rdata;

  // clear_req outranks any same-cycle port access
  assign w_rd_fire = (state_q == ST_READY) && !clear_req && rd_en;
  assign w_wr_fire = (state_q == ST_READY) && !clear_req && wr_en;
  assign busy      = (state_q == ST_CLEAR);
  assign dout      = dout_q;
  assign rd_valid  = rd_valid_q;

  always_comb begin
    w_merged = mem_q[wr_addr];
    for (int b = 0; b < C_NBYTES; b++) begin
      if (wr_be[b]) w_merged[8*b +: 8] = din[8*b +: 8];
    end
  end

  assign w_rdata = ((RDW_MODE == 1) && w_wr_fire && (wr_addr == rd_addr)) ? w_merged
                                                                          : mem_q[rd_addr];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
      sweep_q <= '0;
    end else if (clear_req) begin
      state_q <= ST_CLEAR;
      sweep_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      sweep_q <= sweep_q + 1'b1;
      if (sweep_q == '1) state_q <= ST_READY;
    end
  end

  // Array has no reset; the sweep defines its contents before busy falls
  always_ff @(posedge clock) begin
    if (state_q == ST_CLEAR) begin
      mem_q[sweep_q] <= '0;
    end else if (w_wr_fire) begin
      mem_q[wr_addr] <= w_merged;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [BRAM_DATA_WIDTH-1:0] s1_data_q;
      logic                       s1_valid_q;

      // Stage 1 drains regardless of clear_req so in-flight reads finish
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          s1_data_q  <= '0;
          s1_valid_q <= 1'b0;
          dout_q     <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          s1_valid_q <= w_rd_fire;
          if (w_rd_fire) s1_data_q <= w_rdata;
          rd_valid_q <= s1_valid_q;
          if (s1_valid_q) dout_q <= s1_data_q;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          dout_q     <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= w_rd_fire;
          if (w_rd_fire) dout_q <= w_rdata;
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bram_sync_be.sv
// tb_bram_sync_be: scoreboard bench driving two bram_sync_be instances (latency 1/old-data, latency 2/new-data).
`timescale 1ns/1ps
`default_nettype none

module tb_bram_sync_be;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  logic          clock     = 1'b0;
  logic          reset_n   = 1'b0;
  logic          clear_req = 1'b0;
  logic          rd_en     = 1'b0;
  logic          wr_en     = 1'b0;
  logic [AW-1:0] rd_addr   = '0;
  logic [AW-1:0] wr_addr   = '0;
  logic [NB-1:0] wr_be     = '0;
  logic [DW-1:0] din       = '0;

  logic          busy_a, busy_b, rv_a, rv_b;
  logic [DW-1:0] dout_a, dout_b;

  always #5 clock = ~clock;

  bram_sync_be #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .READ_LATENCY(1), .RDW_MODE(0)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .busy(busy_a),
    .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_be(wr_be), .din(din), .dout(dout_a), .rd_valid(rv_a)
  );

  bram_sync_be #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .READ_LATENCY(2), .RDW_MODE(1)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .busy(busy_b),
    .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_be(wr_be), .din(din), .dout(dout_b), .rd_valid(rv_b)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          qa[$];
  exp_t          qb[$];
  logic [DW-1:0] mem_m [DEPTH];
  int            busy_left = 0;
  bit            known     = 1'b0;
  int            cyc       = 0;
  int            checks    = 0;
  int            errors    = 0;
  logic [DW-1:0] last_a    = '0;
  logic [DW-1:0] last_b    = '0;

  always @(posedge clock) cyc <= cyc + 1;

  // One clock of stimulus; the model advances with the inputs it just applied
  task automatic step(input logic rn, input logic cr, input logic re, input logic [AW-1:0] ra,
                      input logic we, input logic [AW-1:0] wa, input logic [NB-1:0] be,
                      input logic [DW-1:0] d);
    logic [DW-1:0] old_w;
    logic [DW-1:0] new_w;
    @(negedge clock);
    if (known) begin
      checks++;
      if (busy_a !== (busy_left > 0)) begin
        errors++;
        $display("FAIL busy_a: got %b expected %b at cycle %0d", busy_a, busy_left > 0, cyc);
      end
      checks++;
      if (busy_b !== (busy_left > 0)) begin
        errors++;
        $display("FAIL busy_b: got %b expected %b at cycle %0d", busy_b, busy_left > 0, cyc);
      end
    end
    reset_n = rn; clear_req = cr; rd_en = re; rd_addr = ra;
    wr_en = we; wr_addr = wa; wr_be = be; din = d;
    if (!rn) begin
      known = 1'b1;
      busy_left = DEPTH;
      qa.delete();
      qb.delete();
      last_a = '0;
      last_b = '0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    end else if (cr) begin
      busy_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      old_w = mem_m[ra];
      new_w = mem_m[wa];
      for (int b = 0; b < NB; b++) if (be[b]) new_w[8*b +: 8] = d[8*b +: 8];
      if (re) begin
        qa.push_back('{old_w, cyc + 1});
        qb.push_back('{(we && wa == ra) ? new_w : old_w, cyc + 2});
      end
      if (we) mem_m[wa] = new_w;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b1, 1'b0, 1'b1, a, 1'b0, '0, '0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, a, be, d);
  endtask

  task automatic noisy(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b0, 1'($urandom), AW'($urandom), 1'($urandom), AW'($urandom), NB'($urandom), $urandom);
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents rd_valid
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (known) begin
        if (qa.size() > 0 && qa[0].due < cyc) begin
          checks++; errors++;
          $display("FAIL rd_valid_a missing: expected pulse at cycle %0d, now %0d", qa[0].due, cyc);
          void'(qa.pop_front());
        end
        checks++;
        if (rv_a === 1'b1) begin
          if (qa.size() == 0) begin
            errors++;
            $display("FAIL rd_valid_a unexpected: got 1 expected 0 at cycle %0d", cyc);
          end else begin
            e = qa.pop_front();
            if (dout_a !== e.data || cyc != e.due) begin
              errors++;
              $display("FAIL read_a: got %h at cycle %0d expected %h at cycle %0d", dout_a, cyc, e.data, e.due);
            end
            last_a = e.data;
          end
        end else if (rv_a !== 1'b0 || dout_a !== last_a) begin
          errors++;
          $display("FAIL hold_a: got rd_valid %b dout %h expected 0 and %h at cycle %0d", rv_a, dout_a, last_a, cyc);
        end

        if (qb.size() > 0 && qb[0].due < cyc) begin
          checks++; errors++;
          $display("FAIL rd_valid_b missing: expected pulse at cycle %0d, now %0d", qb[0].due, cyc);
          void'(qb.pop_front());
        end
        checks++;
        if (rv_b === 1'b1) begin
          if (qb.size() == 0) begin
            errors++;
            $display("FAIL rd_valid_b unexpected: got 1 expected 0 at cycle %0d", cyc);
          end else begin
            e = qb.pop_front();
            if (dout_b !== e.data || cyc != e.due) begin
              errors++;
              $display("FAIL read_b: got %h at cycle %0d expected %h at cycle %0d", dout_b, cyc, e.data, e.due);
            end
            last_b = e.data;
          end
        end else if (rv_b !== 1'b0 || dout_b !== last_b) begin
          errors++;
          $display("FAIL hold_b: got rd_valid %b dout %h expected 0 and %h at cycle %0d", rv_b, dout_b, last_b, cyc);
        end
      end
    end
  end

  initial begin
    logic [AW-1:0] ra, wa;
    repeat (3) step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
    noisy(DEPTH);
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));
    idle(3);

    wr(AW'(5), 4'b1111, 32'hDEADBEEF);
    wr(AW'(5), 4'b0010, 32'h00001200);
    rd(AW'(5));
    wr(AW'(5), 4'b0000, 32'hFFFFFFFF);
    rd(AW'(5));
    idle(3);

    wr(AW'(9), 4'b1111, 32'h11111111);
    step(1'b1, 1'b0, 1'b1, AW'(9), 1'b1, AW'(9), 4'b1111, 32'h22222222);
    step(1'b1, 1'b0, 1'b1, AW'(9), 1'b1, AW'(9), 4'b0100, 32'h00AB0000);
    step(1'b1, 1'b0, 1'b1, AW'(9), 1'b1, AW'(10), 4'b1111, 32'h33333333);
    idle(3);

    wr(AW'(63), 4'b1111, 32'hA5A5A5A5);
    rd(AW'(63));
    step(1'b1, 1'b1, 1'b1, AW'(63), 1'b1, AW'(63), 4'b1111, 32'h12345678);
    noisy(9);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
    noisy(DEPTH);
    rd(AW'(63));
    idle(3);

    for (int i = 0; i < 8; i++) wr(AW'(i), 4'b1111, 32'h0100_0000 * (i + 1) + i);
    for (int i = 0; i < 8; i++) rd(AW'(i));
    idle(3);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        ra = AW'($urandom_range(0, 7));
        wa = AW'($urandom_range(0, 7));
      end else begin
        ra = AW'($urandom);
        wa = AW'($urandom);
      end
      step(1'($urandom_range(0, 999) != 0), 1'($urandom_range(0, 249) == 0),
           1'($urandom), ra, 1'($urandom), wa, NB'($urandom), $urandom);
    end
    idle(DEPTH + 2);

    step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
    idle(30);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
    noisy(DEPTH);
    wr(AW'(1), 4'b1111, 32'hCAFEF00D);
    rd(AW'(1));
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
    noisy(DEPTH);
    rd(AW'(1));
    idle(5);

    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d reads pending expected 0/0", qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
